// File: rtl/c432_sched_if.sv
// Handshake bundle for the three-bus interrupt scheduler.
// master: requests, channel enables, ack; slave: grant, pending flags, timeout.
interface c432_sched_if;
  logic [8:0] req_a;
  logic [8:0] req_b;
  logic [8:0] req_c;
  logic [8:0] chan_en;
  logic       ack;
  logic       irq_valid;
  logic [1:0] irq_bus;
  logic [3:0] irq_chan;
  logic [2:0] bus_pend;
  logic       timeout;

  modport master (
    output req_a, req_b, req_c, chan_en, ack,
    input  irq_valid, irq_bus, irq_chan, bus_pend, timeout
  );

  modport slave (
    input  req_a, req_b, req_c, chan_en, ack,
    output irq_valid, irq_bus, irq_chan, bus_pend, timeout
  );
endinterface

// File: rtl/c432_sched.sv
// Three-bus, nine-channel sticky interrupt scheduler with aging and grant timeout.
// Ports: clk, rst_n (async, active-low), irq (c432_sched_if.slave bundle).
module c432_sched #(
  parameter int TIMEOUT = 16,
  parameter int AGE_MAX = 4
) (
  input logic         clk,
  input logic         rst_n,
  c432_sched_if.slave irq
);

  localparam logic [3:0] AMAX  = 4'(AGE_MAX);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [26:0] pending;
  logic [26:0] clr;
  logic [8:0]  ea, eb, ec;
  logic [8:0]  onehot;
  logic [8:0]  sel_vec;
  logic [1:0]  sel_bus;
  logic [3:0]  sel_chan;
  logic [3:0]  age_b, age_c;
  logic [3:0]  hold_b, hold_c;
  logic [3:0]  nage_b, nage_c;
  logic [7:0]  timer;
  logic        any_el;
  logic        prom_b, prom_c;

  function automatic logic [3:0] lowest(input logic [8:0] v);
    lowest = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (v[i]) lowest = 4'(i);
  endfunction

  // Counters stop at AGE_MAX so a promoted bus that still loses
  // (B while C is also promoted) stays promoted.
  function automatic logic [3:0] age_nx(
    input logic [3:0] a,
    input logic       won,
    input logic       el
  );
    if (won)
      age_nx = 4'd0;
    else if (el && a < AMAX)
      age_nx = a + 4'd1;
    else
      age_nx = a;
  endfunction

  assign ea = pending[8:0]   & irq.chan_en;
  assign eb = pending[17:9]  & irq.chan_en;
  assign ec = pending[26:18] & irq.chan_en;

  assign any_el = |{ea, eb, ec};
  assign irq.bus_pend = {|ec, |eb, |ea};

  assign prom_b = (age_b == AMAX);
  assign prom_c = (age_c == AMAX);

  always_comb begin
    sel_bus = 2'd0;
    sel_vec = ea;
    if (prom_c && |ec) begin
      sel_bus = 2'd2;
      sel_vec = ec;
    end else if (prom_b && |eb) begin
      sel_bus = 2'd1;
      sel_vec = eb;
    end else if (|ea) begin
      sel_bus = 2'd0;
      sel_vec = ea;
    end else if (|eb) begin
      sel_bus = 2'd1;
      sel_vec = eb;
    end else begin
      sel_bus = 2'd2;
      sel_vec = ec;
    end
  end

  assign sel_chan = lowest(sel_vec);
  assign nage_b = age_nx(age_b, sel_bus == 2'd1, |eb);
  assign nage_c = age_nx(age_c, sel_bus == 2'd2, |ec);

  assign onehot = 9'b1 << irq.irq_chan;

  always_comb begin
    clr = '0;
    if (state == GRANT && irq.ack) begin
      unique case (irq.irq_bus)
        2'd0:    clr = {18'b0, onehot};
        2'd1:    clr = {9'b0, onehot, 9'b0};
        2'd2:    clr = {onehot, 18'b0};
        default: clr = '0;
      endcase
    end
  end

  // Ages are computed at selection but only committed on ack,
  // so a timed-out grant leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      age_b         <= '0;
      age_c         <= '0;
      hold_b        <= '0;
      hold_c        <= '0;
      timer         <= '0;
      irq.irq_valid <= 1'b0;
      irq.irq_bus   <= 2'd0;
      irq.irq_chan  <= 4'd0;
      irq.timeout   <= 1'b0;
    end else begin
      pending     <= (pending & ~clr) | {irq.req_c, irq.req_b, irq.req_a};
      irq.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_el) begin
            state         <= GRANT;
            irq.irq_valid <= 1'b1;
            irq.irq_bus   <= sel_bus;
            irq.irq_chan  <= sel_chan;
            timer         <= '0;
            hold_b        <= nage_b;
            hold_c        <= nage_c;
          end
        end
        GRANT: begin
          if (irq.ack) begin
            state         <= IDLE;
            irq.irq_valid <= 1'b0;
            age_b         <= hold_b;
            age_c         <= hold_c;
          end else if (timer == TLAST) begin
            state         <= IDLE;
            irq.irq_valid <= 1'b0;
            irq.timeout   <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c432_sched.sv
// Bench for c432_sched: vector table, corner sequences, random vs reference model.
// Drives the interface master side; one summary line at the end.
module tb_c432_sched;

  localparam int TO = 16;
  localparam int AM = 4;

  logic clk;
  logic rst_n;

  c432_sched_if irq ();

  c432_sched #(.TIMEOUT(TO), .AGE_MAX(AM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  bit [8:0] mp[3];
  int       mage[3];
  int       mhold[3];
  bit       m_valid;
  bit       m_to;
  int       m_bus;
  int       m_chan;
  int       m_cnt;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] c;
    logic [8:0] en;
    logic       ack;
    logic       ev;
    logic [1:0] eb;
    logic [3:0] ec;
    logic [2:0] ep;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      mp[b] = '0;
      mage[b] = 0;
      mhold[b] = 0;
    end
    m_valid = 0;
    m_to = 0;
    m_bus = 0;
    m_chan = 0;
    m_cnt = 0;
  endtask

  function automatic int first_bit(input bit [8:0] v);
    for (int i = 0; i < 9; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  // One clock of the scheduler, from the rules: sticky requests,
  // ack clears unless re-requested, aging promotes starved buses.
  task automatic model_step();
    bit [8:0] rq[3];
    bit [8:0] el[3];
    bit [8:0] en;
    int win;
    rq[0] = irq.req_a;
    rq[1] = irq.req_b;
    rq[2] = irq.req_c;
    en = irq.chan_en;
    for (int b = 0; b < 3; b++) el[b] = mp[b] & en;
    m_to = 0;
    if (m_valid) begin
      if (irq.ack) begin
        mp[m_bus][m_chan] = 1'b0;
        m_valid = 0;
        mage[1] = mhold[1];
        mage[2] = mhold[2];
      end else if (m_cnt == TO) begin
        m_valid = 0;
        m_to = 1;
      end else begin
        m_cnt++;
      end
    end else if ((el[0] | el[1] | el[2]) != 0) begin
      win = -1;
      if (mage[2] == AM && el[2] != 0) win = 2;
      else if (mage[1] == AM && el[1] != 0) win = 1;
      else
        for (int b = 0; b < 3; b++)
          if (win < 0 && el[b] != 0) win = b;
      m_bus = win;
      m_chan = first_bit(el[win]);
      m_valid = 1;
      m_cnt = 1;
      for (int b = 1; b < 3; b++) begin
        if (b == win) mhold[b] = 0;
        else if (el[b] != 0) mhold[b] = (mage[b] + 1 > AM) ? AM : mage[b] + 1;
        else mhold[b] = mage[b];
      end
    end
    for (int b = 0; b < 3; b++) mp[b] = mp[b] | rq[b];
  endtask

  task automatic check_model();
    bit [8:0] en;
    int ep;
    en = irq.chan_en;
    ep = {(mp[2] & en) != 0, (mp[1] & en) != 0, (mp[0] & en) != 0};
    chk("m_valid", int'(irq.irq_valid), int'(m_valid));
    chk("m_timeout", int'(irq.timeout), int'(m_to));
    chk("m_bus_pend", int'(irq.bus_pend), ep);
    if (m_valid) begin
      chk("m_irq_bus", int'(irq.irq_bus), m_bus);
      chk("m_irq_chan", int'(irq.irq_chan), m_chan);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!irq.irq_valid && k < 40) begin
      cycle();
      k++;
    end
    if (!irq.irq_valid) chk({nm, "_wait"}, 0, 1);
  endtask

  task automatic drive(input logic [8:0] a, input logic [8:0] b,
                       input logic [8:0] c, input logic [8:0] en,
                       input logic ak);
    irq.req_a = a;
    irq.req_b = b;
    irq.req_c = c;
    irq.chan_en = en;
    irq.ack = ak;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, int'(irq.irq_valid), 0);
    chk({nm, "_bus"}, int'(irq.irq_bus), 0);
    chk({nm, "_chan"}, int'(irq.irq_chan), 0);
    chk({nm, "_pend"}, int'(irq.bus_pend), 0);
    chk({nm, "_to"}, int'(irq.timeout), 0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    model_reset();

    tv[0]  = '{9'h000, 9'h008, 9'h000, 9'h1FF, 1'b0, 1'b0, 2'd0, 4'd0, 3'b010};
    tv[1]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 2'd1, 4'd3, 3'b010};
    tv[2]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000};
    tv[3]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000};
    tv[4]  = '{9'h000, 9'h000, 9'h080, 9'h17F, 1'b0, 1'b0, 2'd0, 4'd0, 3'b000};
    tv[5]  = '{9'h000, 9'h000, 9'h000, 9'h17F, 1'b0, 1'b0, 2'd0, 4'd0, 3'b000};
    tv[6]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 2'd2, 4'd7, 3'b100};
    tv[7]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000};
    tv[8]  = '{9'h024, 9'h000, 9'h001, 9'h1FF, 1'b0, 1'b0, 2'd0, 4'd0, 3'b101};
    tv[9]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 2'd0, 4'd2, 3'b101};
    tv[10] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b101};
    tv[11] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 2'd0, 4'd5, 3'b101};
    tv[12] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b100};
    tv[13] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 2'd2, 4'd0, 3'b100};
    tv[14] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000};

    rst_n = 1'b0;
    drive(9'h0, 9'h0, 9'h0, 9'h1FF, 1'b0);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].c, tv[i].en, tv[i].ack);
      cycle();
      chk($sformatf("tv%0d_valid", i), int'(irq.irq_valid), int'(tv[i].ev));
      chk($sformatf("tv%0d_pend", i), int'(irq.bus_pend), int'(tv[i].ep));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_bus", i), int'(irq.irq_bus), int'(tv[i].eb));
        chk($sformatf("tv%0d_chan", i), int'(irq.irq_chan), int'(tv[i].ec));
      end
    end
    drive(9'h0, 9'h0, 9'h0, 9'h1FF, 1'b0);

    // Aging: A0 requests continuously, C0 must win the fifth selection.
    drive(9'h001, 9'h0, 9'h001, 9'h1FF, 1'b0);
    cycle();
    irq.req_c = 9'h0;
    for (int g = 0; g < 5; g++) begin
      wait_valid("age");
      chk($sformatf("age_g%0d_bus", g), int'(irq.irq_bus), (g < 4) ? 0 : 2);
      chk($sformatf("age_g%0d_chan", g), int'(irq.irq_chan), 0);
      irq.ack = 1'b1;
      cycle();
      irq.ack = 1'b0;
    end
    irq.req_a = 9'h0;
    irq.ack = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    irq.ack = 1'b0;
    chk("age_drain_pend", int'(irq.bus_pend), 0);

    // Timeout: A1 held without ack for TIMEOUT valid cycles.
    irq.req_a = 9'h002;
    cycle();
    irq.req_a = 9'h0;
    wait_valid("to");
    n = 0;
    while (irq.irq_valid && n < 40) begin
      n++;
      cycle();
    end
    chk("to_len", n, TO);
    chk("to_pulse", int'(irq.timeout), 1);
    chk("to_bubble", int'(irq.irq_valid), 0);
    cycle();
    chk("to_regrant_valid", int'(irq.irq_valid), 1);
    chk("to_regrant_chan", int'(irq.irq_chan), 1);
    chk("to_pulse_end", int'(irq.timeout), 0);
    irq.ack = 1'b1;
    cycle();
    irq.ack = 1'b0;

    // Ack with the same request re-asserted keeps the bit pending.
    irq.req_a = 9'h010;
    cycle();
    irq.req_a = 9'h0;
    wait_valid("reack");
    irq.req_a = 9'h010;
    irq.ack = 1'b1;
    cycle();
    irq.req_a = 9'h0;
    irq.ack = 1'b0;
    chk("reack_bubble", int'(irq.irq_valid), 0);
    chk("reack_pend", int'(irq.bus_pend), 1);
    cycle();
    chk("reack_valid", int'(irq.irq_valid), 1);
    chk("reack_chan", int'(irq.irq_chan), 4);

    // Asynchronous reset mid-grant, then restart latency.
    #3;
    rst_n = 1'b0;
    irq.req_a = 9'h010;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("rst_edge1_valid", int'(irq.irq_valid), 0);
    irq.req_a = 9'h0;
    cycle();
    chk("rst_edge2_valid", int'(irq.irq_valid), 1);
    chk("rst_edge2_chan", int'(irq.irq_chan), 4);
    irq.ack = 1'b1;
    cycle();
    irq.ack = 1'b0;

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      irq.req_a = ($urandom_range(0, 3) == 0) ? 9'($urandom) & 9'($urandom) : 9'h0;
      irq.req_b = ($urandom_range(0, 3) == 0) ? 9'($urandom) & 9'($urandom) : 9'h0;
      irq.req_c = ($urandom_range(0, 3) == 0) ? 9'($urandom) & 9'($urandom) : 9'h0;
      if ($urandom_range(0, 7) == 0)
        irq.chan_en = 9'($urandom) | 9'($urandom);
      irq.ack = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c432_sched.md
C432_SCHED -- requirements
Module: c432_sched

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 16, the number of cycles a grant may wait for ack before it is withdrawn (legal range 2..255).
REQ-002 SHALL provide parameter AGE_MAX, default 4, the number of lost selections after which a lower-priority bus is promoted (legal range 1..15).

Interface
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have req_a, input, 9, bus A interrupt request lines, channels 0..8.
REQ-006 SHALL have req_b, input, 9, bus B interrupt request lines.
REQ-007 SHALL have req_c, input, 9, bus C interrupt request lines.
REQ-008 SHALL have chan_en, input, 9, per-channel enable mask applied to all three buses.
REQ-009 SHALL have ack, input, 1, requester acknowledge of the current grant.
REQ-010 SHALL have irq_valid, output, 1, a grant is being presented.
REQ-011 SHALL have irq_bus, output, 2, granted bus: 0=A, 1=B, 2=C; 3 is never driven.
REQ-012 SHALL have irq_chan, output, 4, granted channel 0..8.
REQ-013 SHALL have bus_pend, output, 3, {C,B,A} flags: any enabled pending bit on that bus.
REQ-014 SHALL have timeout, output, 1, one-cycle pulse when a grant is withdrawn.

Function
REQ-015 SHALL hold a 27-bit pending register; a bit sets in any cycle its req line is 1 (sticky, level-sampled).
REQ-016 SHALL clear a pending bit only on the cycle ack=1 while that bit is granted; if its req line is also 1 that cycle, set wins and the bit stays 1.
REQ-017 SHALL treat a pending bit as eligible only when its chan_en bit is 1; masked bits are retained and not lost.
REQ-018 SHALL drive bus_pend combinationally from the registered pending bits ANDed with chan_en.
REQ-019 SHALL use the FSM states IDLE and GRANT.
REQ-020 In IDLE, when any eligible bit exists, SHALL register the selection and enter GRANT, with irq_valid=1 on the next cycle (1-cycle latency from pending to valid).
REQ-021 SHALL use default selection priority bus A > B > C, and within a bus the lowest channel index.
REQ-022 SHALL keep a saturating 4-bit age counter for each of buses B and C, incremented when a selection goes to a higher-priority bus while that bus has an eligible bit, and cleared when that bus is selected.
REQ-023 SHALL give a bus whose age counter equals AGE_MAX top priority for the next selection; if both B and C are promoted, C wins.
REQ-024 In GRANT, SHALL hold irq_valid, irq_bus and irq_chan stable regardless of req/chan_en changes until ack or timeout.
REQ-025 In GRANT with ack=1, SHALL clear the granted bit and return to IDLE, giving one idle bubble cycle with irq_valid=0 between grants.
REQ-026 SHALL count GRANT cycles; if ack is still 0 after TIMEOUT cycles, SHALL pulse timeout for 1 cycle, keep the pending bit, and return to IDLE.
REQ-027 SHALL not update the age counters on a timed-out grant.
REQ-028 SHALL ignore ack in IDLE.

Reset
REQ-029 On rst_n=0, SHALL immediately clear pending, age counters and timer; state=IDLE; irq_valid=0, irq_bus=0, irq_chan=0, timeout=0, bus_pend=0.
REQ-030 When reset is asserted mid-grant, SHALL abandon the grant without a timeout pulse; after rst_n deasserts, the first selection SHALL occur no earlier than the second rising edge.

Verification
REQ-031 req_b[3]=1 pulse, chan_en=9'h1FF -> next cycle valid=1, bus=1, chan=3; ack -> pending cleared, bus_pend=0.
REQ-032 req_a[5], req_a[2] and req_c[0] pending together -> grant order A2, A5, C0, with one bubble between grants.
REQ-033 Bus A continuously requesting, C0 pending, AGE_MAX=4 -> after 4 A grants, the 5th grant is C0.
REQ-034 Grant A1 with ack held 0, TIMEOUT=16 -> timeout pulses after 16 valid cycles, then A1 is re-granted after one bubble.
REQ-035 chan_en[7]=0 with req_c[7] pending -> no grant and bus_pend=0; set chan_en[7]=1 -> C7 granted the next cycle.
REQ-036 Ack in the same cycle as req re-asserted on the granted bit -> bit stays pending and is re-granted; rst_n low mid-grant -> all outputs 0 asynchronously.
